nano_mem: RTL and testbench

- 256x16 memory responder on the far side of the NanoCPU memory interface.
- Services the CPU's combinational read and synchronous write port.
- Contains a byte-serial boot loader that fills the array before the CPU runs. While the loader is active, the CPU is held in reset via cpu_rst.
- Sits at top level between the CPU and a host/UART byte source.

---
 rtl/nano_mem_pkg.sv | 17 +
 rtl/nano_mem_loader.sv | 104 ++++++++++
 rtl/nano_mem.sv | 74 +++++++
 tb/tb_nano_mem.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nano_mem_pkg.sv
// nano_mem shared types and constants.
// Loader FSM states and memory geometry.
package nano_mem_pkg;

    localparam int MEM_AW = 8;
    localparam int MEM_DW = 16;
    localparam int LD_BW  = 8;

    typedef enum logic [2:0] {
        S_WAIT,
        S_LEN,
        S_HI,
        S_LO,
        S_RUN
    } LdState;

endpackage

// File: rtl/nano_mem_loader.sv
// Byte-serial boot loader for nano_mem.
// Holds the CPU in reset while a length-prefixed word stream is written.
module nano_mem_loader
    import nano_mem_pkg::*;
#(
    parameter int BOOT_ON_RESET = 1
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [LD_BW-1:0]  ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              cpu_rst,
    output logic              wr_en,
    output logic [MEM_AW-1:0] wr_addr,
    output logic [MEM_DW-1:0] wr_data,
    output logic              run
);

    localparam LdState RST_ST =
        (BOOT_ON_RESET != 0) ? S_WAIT : S_RUN;

    LdState             r_state;
    LdState             w_state_n;
    logic [MEM_AW:0]    r_cnt;
    logic [MEM_AW:0]    w_cnt_n;
    logic [MEM_AW-1:0]  r_waddr;
    logic [MEM_AW-1:0]  w_waddr_n;
    logic [LD_BW-1:0]   r_hi;
    logic [LD_BW-1:0]   w_hi_n;
    logic               r_done;
    logic               w_done_n;

    // Next-state and counter updates; a byte moves only when ld_valid is high.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_waddr_n = r_waddr;
        w_hi_n    = r_hi;
        w_done_n  = 1'b0;
        unique case (r_state)
            S_WAIT, S_RUN: begin
                if (ld_start) w_state_n = S_LEN;
            end
            S_LEN: begin
                if (ld_valid) begin
                    w_cnt_n   = (ld_data == 8'd0) ? 9'd256
                                                  : {1'b0, ld_data};
                    w_waddr_n = '0;
                    w_state_n = S_HI;
                end
            end
            S_HI: begin
                if (ld_valid) begin
                    w_hi_n    = ld_data;
                    w_state_n = S_LO;
                end
            end
            S_LO: begin
                if (ld_valid) begin
                    w_waddr_n = r_waddr + 8'd1;
                    w_cnt_n   = r_cnt - 9'd1;
                    if (r_cnt == 9'd1) begin
                        w_state_n = S_RUN;
                        w_done_n  = 1'b1;
                    end else begin
                        w_state_n = S_HI;
                    end
                end
            end
            default: w_state_n = RST_ST;
        endcase
    end

    // State and counter registers; reset abandons any partial load.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_state <= RST_ST;
            r_cnt   <= '0;
            r_waddr <= '0;
            r_hi    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_waddr <= w_waddr_n;
            r_hi    <= w_hi_n;
            r_done  <= w_done_n;
        end
    end

    assign ld_ready = (r_state == S_LEN) ||
                      (r_state == S_HI)  ||
                      (r_state == S_LO);
    assign ld_done  = r_done;
    assign run      = (r_state == S_RUN);
    assign cpu_rst  = rst || (r_state != S_RUN);
    assign wr_en    = (r_state == S_LO) && ld_valid;
    assign wr_addr  = r_waddr;
    assign wr_data  = {r_hi, ld_data};

endmodule

// File: rtl/nano_mem.sv
// 256x16 memory responder for the NanoCPU.
// CPU owns the write port in S_RUN, the boot loader otherwise.
module nano_mem
    import nano_mem_pkg::*;
#(
    parameter int DEPTH         = 256,
    parameter int BOOT_ON_RESET = 1
) (
    input  logic              ck,
    input  logic              rst,
    input  logic [MEM_AW-1:0] address,
    output logic [MEM_DW-1:0] dataR,
    input  logic [MEM_DW-1:0] dataW,
    input  logic              ce,
    input  logic              we,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [LD_BW-1:0]  ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              cpu_rst
);

    logic [MEM_DW-1:0] r_mem [DEPTH];

    logic              w_ld_we;
    logic [MEM_AW-1:0] w_ld_addr;
    logic [MEM_DW-1:0] w_ld_data;
    logic              w_run;
    logic              w_we;
    logic [MEM_AW-1:0] w_waddr;
    logic [MEM_DW-1:0] w_wdata;

    nano_mem_loader #(
        .BOOT_ON_RESET (BOOT_ON_RESET)
    ) u_loader (
        .ck       (ck),
        .rst      (rst),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .cpu_rst  (cpu_rst),
        .wr_en    (w_ld_we),
        .wr_addr  (w_ld_addr),
        .wr_data  (w_ld_data),
        .run      (w_run)
    );

    // Write-port mux: CPU while running, loader otherwise.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (w_run) begin
            w_we    = ce && we;
            w_waddr = address;
            w_wdata = dataW;
        end else begin
            w_we    = w_ld_we;
            w_waddr = w_ld_addr;
            w_wdata = w_ld_data;
        end
    end

    // Array write; contents survive reset on purpose.
    always_ff @(posedge ck) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    assign dataR = ce ? r_mem[address] : '0;

endmodule

// File: tb/tb_nano_mem.sv
// Randomized scoreboard bench for nano_mem.
// Reads are checked by a negedge monitor against a queue of expectations.
module tb_nano_mem;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  address = '0;
    logic [15:0] dataR;
    logic [15:0] dataW = '0;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        ld_ready;
    logic        ld_done;
    logic        cpu_rst;

    nano_mem #(
        .DEPTH         (256),
        .BOOT_ON_RESET (1)
    ) dut (
        .ck       (ck),
        .rst      (rst),
        .address  (address),
        .dataR    (dataR),
        .dataW    (dataW),
        .ce       (ce),
        .we       (we),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .cpu_rst  (cpu_rst)
    );

    always #5 ck = ~ck;

    int total = 0;
    int bad   = 0;
    int n_done  = 0;
    int n_loads = 0;

    // reference model: memory image and whether the CPU is running
    logic [15:0] ref_mem [256];
    bit          known   [256];
    bit          model_run = 1'b0;

    logic [15:0] exp_q [$];
    logic [7:0]  adr_q [$];
    logic        rd_req = 1'b0;
    logic [7:0]  stream [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // monitor: pops one expectation per presented read
    always @(negedge ck) begin
        if (ld_done === 1'b1) n_done++;
        if (rd_req) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_underflow: got %0h want none", dataR);
            end else begin
                logic [15:0] e;
                logic [7:0]  a;
                e = exp_q.pop_front();
                a = adr_q.pop_front();
                chk($sformatf("read[%02h]", a), {16'h0, dataR}, {16'h0, e});
            end
        end
    end

    task automatic do_read(input logic [7:0] a, input logic c);
        address = a;
        ce      = c;
        we      = 1'b0;
        exp_q.push_back(c ? ref_mem[a] : 16'h0000);
        adr_q.push_back(a);
        rd_req = 1'b1;
        @(posedge ck); #1;
        rd_req = 1'b0;
        ce     = 1'b0;
    endtask

    // write; a same-cycle read must still see the old word
    task automatic cpu_write(input logic [7:0] a, input logic [15:0] d);
        address = a;
        dataW   = d;
        ce      = 1'b1;
        we      = 1'b1;
        if (known[a]) begin
            exp_q.push_back(ref_mem[a]);
            adr_q.push_back(a);
            rd_req = 1'b1;
        end
        @(posedge ck); #1;
        rd_req = 1'b0;
        we     = 1'b0;
        ce     = 1'b0;
        if (model_run) begin
            ref_mem[a] = d;
            known[a]   = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge ck); #1;
        chk("rst_cpu_rst", {31'h0, cpu_rst}, 32'h1);
        chk("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
        chk("rst_ld_done", {31'h0, ld_done}, 32'h0);
        rst = 1'b0;
        model_run = 1'b0;
        ld_valid  = 1'b0;
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        @(posedge ck); #1;
        ld_start  = 1'b0;
        model_run = 1'b0;
        chk("start_cpu_rst", {31'h0, cpu_rst}, 32'h1);
        chk("start_ready", {31'h0, ld_ready}, 32'h1);
    endtask

    // sends the global stream; model derives words from the byte rules
    task automatic load_stream(input int gapmax, input bit start_mid);
        int         left;
        logic [7:0] hi;
        logic [7:0] wa;
        bit         last;
        left = 0;
        hi   = '0;
        wa   = '0;
        pulse_start();
        for (int i = 0; i < stream.size(); i++) begin
            bit acc;
            int cyc;
            repeat ($urandom_range(gapmax, 0)) begin
                ld_valid = 1'b0;
                ld_data  = 8'($urandom);
                @(posedge ck); #1;
            end
            ld_valid = 1'b1;
            ld_data  = stream[i];
            if (start_mid && i == 2) ld_start = 1'b1;
            cyc = 0;
            do begin
                acc = ld_ready;
                @(posedge ck); #1;
                cyc++;
                if (cyc > 64) begin
                    bad++;
                    total++;
                    $display("FAIL ld_timeout: got no accept want accept");
                    $display("test done: total=%0d bad=%0d", total, bad);
                    $fatal(1, "loader stalled");
                end
            end while (!acc);
            ld_valid = 1'b0;
            ld_start = 1'b0;
            last = 1'b0;
            if (i == 0) begin
                left = (stream[i] == 8'd0) ? 256 : int'(stream[i]);
                wa   = '0;
            end else if (i % 2 == 1) begin
                hi = stream[i];
            end else begin
                ref_mem[wa] = {hi, stream[i]};
                known[wa]   = 1'b1;
                wa++;
                left--;
                last = (left == 0);
            end
            if (last || i == stream.size() - 1 || i < 3) begin
                chk($sformatf("done_b%0d", i), {31'h0, ld_done},
                    {31'h0, last});
                chk($sformatf("cpurst_b%0d", i), {31'h0, cpu_rst},
                    {31'h0, !last});
            end else if (ld_done !== 1'b0) begin
                chk($sformatf("early_done_b%0d", i), {31'h0, ld_done},
                    32'h0);
            end
            if (last) begin
                model_run = 1'b1;
                n_loads++;
                @(posedge ck); #1;
                chk("done_one_cycle", {31'h0, ld_done}, 32'h0);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = '0;
            known[i]   = 1'b0;
        end

        repeat (2) @(posedge ck);
        #1;
        do_reset();
        repeat (5) @(posedge ck);
        #1;
        chk("idle_cpu_rst", {31'h0, cpu_rst}, 32'h1);
        chk("idle_ready", {31'h0, ld_ready}, 32'h0);

        stream = '{8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h07};
        load_stream(0, 1'b0);
        chk("basic_w0", {16'h0, ref_mem[0]}, 32'h1234);
        chk("basic_w1", {16'h0, ref_mem[1]}, 32'hABCD);
        chk("basic_w2", {16'h0, ref_mem[2]}, 32'h0007);
        do_read(8'd1, 1'b1);
        do_read(8'd0, 1'b1);
        do_read(8'd2, 1'b1);
        for (int i = 0; i < 4; i++) do_read(8'($urandom), 1'b0);

        cpu_write(8'h80, 16'hBEEF);
        do_read(8'h80, 1'b1);

        stream = '{8'h00};
        for (int i = 0; i < 512; i++) stream.push_back(8'($urandom));
        load_stream(2, 1'b0);
        for (int i = 0; i < 256; i++) do_read(8'(i), 1'b1);

        ld_valid = 1'b1;
        ld_data  = 8'h5A;
        repeat (3) @(posedge ck);
        #1;
        chk("run_ready", {31'h0, ld_ready}, 32'h0);
        chk("run_cpu_rst", {31'h0, cpu_rst}, 32'h0);
        ld_valid = 1'b0;
        do_read(8'h00, 1'b1);
        do_read(8'h01, 1'b1);

        do_reset();
        cpu_write(8'h80, 16'h1111);
        do_read(8'h80, 1'b1);
        do_read(8'h7F, 1'b1);

        stream = '{8'h02, 8'hC0, 8'hDE, 8'hF0, 8'h0D};
        load_stream(1, 1'b1);
        do_read(8'h00, 1'b1);
        do_read(8'h01, 1'b1);
        do_read(8'h02, 1'b1);

        for (int i = 0; i < 20; i++) begin
            logic [7:0] a;
            a = 8'($urandom);
            if ($urandom_range(1, 0) == 1) cpu_write(a, 16'($urandom));
            do_read(a, 1'b1);
        end

        stream = '{8'h02, 8'h11, 8'h22, 8'h33};
        load_stream(1, 1'b0);
        do_reset();
        chk("abort_cpu_rst", {31'h0, cpu_rst}, 32'h1);
        do_read(8'h00, 1'b1);
        do_read(8'h01, 1'b1);

        stream = '{8'h01, 8'h9A, 8'hBC};
        load_stream(0, 1'b0);
        do_read(8'h00, 1'b1);
        do_read(8'h01, 1'b1);

        repeat (2) @(posedge ck);
        #1;
        chk("done_pulses", n_done, n_loads);
        chk("rd_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
